// File: rtl/checkbits_seq_monitor_pkg.sv
// Shared types and default marker codes for the checkbits sequence monitor.
package checkbits_mon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CHECK,
        WAIT_END,
        PASS,
        FAIL,
        TMO
    } mon_state_t;

    localparam logic [15:0] CHK_START = 16'hAB50;
    localparam logic [15:0] CHK_END   = 16'hAB51;

    function automatic logic is_busy(input mon_state_t s);
        return (s == WAIT_START) || (s == CHECK) || (s == WAIT_END);
    endfunction

endpackage

// File: rtl/checkbits_seq_monitor_if.sv
// Table-load port of the checkbits monitor.
// Handshake: a word transfers on a rising clock edge where load_valid_i && load_ready_o;
// the master holds load_data_i stable while load_valid_i is high, ready never depends on valid.
interface checkbits_seq_monitor_if #(
    parameter int CHK_W = 16
);
    logic             load_valid_i;
    logic [CHK_W-1:0] load_data_i;
    logic             load_ready_o;

    modport master (output load_valid_i, output load_data_i, input load_ready_o);
    modport slave  (input load_valid_i, input load_data_i, output load_ready_o);
endinterface

// File: rtl/checkbits_seq_monitor_stable_filter.sv
// Turns a slowly-changing bus into single-cycle events once a new value has held STABLE_CYC cycles.
module chk_stable_filter #(
    parameter int CHK_W      = 16,
    parameter int STABLE_CYC = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [CHK_W-1:0] chk_i,
    output logic             evt_o,
    output logic [CHK_W-1:0] evt_val_o
);
    localparam int              CNT_W   = $clog2(STABLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);

    logic [CHK_W-1:0] prev_q;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             pend_q, pend_d, fire;

    // pend marks a value that has not produced its event yet; reset counts as a change
    always_comb begin
        hold_d = hold_q;
        pend_d = pend_q;
        if (chk_i != prev_q) begin
            hold_d = CNT_W'(1);
            pend_d = 1'b1;
        end else if (hold_q != CNT_MAX) begin
            hold_d = hold_q + CNT_W'(1);
        end
        fire = pend_d && (hold_d == CNT_MAX);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            prev_q    <= '0;
            hold_q    <= '0;
            pend_q    <= 1'b1;
            evt_o     <= 1'b0;
            evt_val_o <= '0;
        end else begin
            prev_q <= chk_i;
            hold_q <= hold_d;
            pend_q <= pend_d && !fire;
            evt_o  <= fire;
            if (fire) evt_val_o <= chk_i;
        end
    end

endmodule

// File: rtl/checkbits_seq_monitor.sv
// On-chip progress checker: arms on a start marker, matches a loaded code table in order,
// then requires an end marker; reports pass / strict fail / timeout as sticky flags.
module checkbits_seq_monitor
    import checkbits_mon_pkg::*;
#(
    parameter int CHK_W      = 16,
    parameter int DEPTH      = 32,
    parameter int STABLE_CYC = 4,
    parameter int TMO_W      = 24,
    parameter int STRICT     = 0
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [CHK_W-1:0]       chk_i,
    input  logic [CHK_W-1:0]       start_code_i,
    input  logic [CHK_W-1:0]       end_code_i,
    input  logic [TMO_W-1:0]       tmo_limit_i,
    checkbits_seq_monitor_if.slave load_if,
    input  logic                   clear_i,
    input  logic                   arm_i,
    output logic                   busy_o,
    output logic                   pass_o,
    output logic                   fail_o,
    output logic                   tmo_o,
    output logic [$clog2(DEPTH):0] idx_o,
    output logic [CHK_W-1:0]       last_evt_o,
    output mon_state_t             state_o
);
    localparam int IDX_W = $clog2(DEPTH) + 1;

    logic [CHK_W-1:0] table_q [DEPTH];
    logic [IDX_W-1:0] count_q, idx_q, idx_d;
    logic [TMO_W-1:0] tmo_cnt_q;
    mon_state_t       state_q, state_d;
    logic             evt, push, arm_ok, busy, expire;
    logic [CHK_W-1:0] evt_val, exp_code;

    chk_stable_filter #(.CHK_W(CHK_W), .STABLE_CYC(STABLE_CYC)) u_filter (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .chk_i     (chk_i),
        .evt_o     (evt),
        .evt_val_o (evt_val)
    );

    assign busy                 = is_busy(state_q);
    assign arm_ok               = arm_i && !busy;
    assign load_if.load_ready_o = (state_q == IDLE) && (count_q != IDX_W'(DEPTH));
    assign push                 = load_if.load_valid_i && load_if.load_ready_o && !clear_i;
    assign exp_code             = table_q[idx_q[IDX_W-2:0]];

    always_ff @(posedge wb_clk_i) begin
        if (push) table_q[count_q[IDX_W-2:0]] <= load_if.load_data_i;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)                        count_q <= '0;
        else if (clear_i && state_q == IDLE) count_q <= '0;
        else if (push)                       count_q <= count_q + IDX_W'(1);
    end

    // Saturates so a long silence can never wrap back onto a small limit
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)                      tmo_cnt_q <= '0;
        else if (arm_ok || evt)            tmo_cnt_q <= '0;
        else if (busy && tmo_cnt_q != '1) tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end

    // tmo_cnt_q counts completed silent cycles, so this cycle is silent cycle tmo_cnt_q+1
    assign expire = busy && !evt && (tmo_limit_i != '0) && (tmo_cnt_q == tmo_limit_i - TMO_W'(1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE, PASS, FAIL, TMO: begin
                if (arm_i) begin
                    state_d = WAIT_START;
                    idx_d   = '0;
                end
            end
            WAIT_START: begin
                if (evt && evt_val == start_code_i)
                    state_d = (count_q == '0) ? WAIT_END : CHECK;
            end
            CHECK: begin
                if (evt) begin
                    if (evt_val == exp_code) begin
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_d == count_q) state_d = WAIT_END;
                    end else if (STRICT != 0) begin
                        state_d = FAIL;
                    end
                end
            end
            WAIT_END: begin
                if (evt) begin
                    if (evt_val == end_code_i) state_d = PASS;
                    else if (STRICT != 0)      state_d = FAIL;
                end
            end
            default: state_d = IDLE;
        endcase
        if (expire) state_d = TMO;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            last_evt_o <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (evt) last_evt_o <= evt_val;
        end
    end

    assign busy_o  = busy;
    assign pass_o  = (state_q == PASS);
    assign fail_o  = (state_q == FAIL);
    assign tmo_o   = (state_q == TMO);
    assign idx_o   = idx_q;
    assign state_o = state_q;

endmodule
